// File: rtl/temp_sample_sequencer.sv
// temp_sample_sequencer
// Periodic sampling controller for the temperature-sensor path. A period
// counter schedules automatic samples, Force requests an immediate one, and
// each sample is a Start/Done exchange with the sensor interface. The returned
// reading is latched into Temp for the display logic.
//
// Optional feature macro: TEMP_TIMEOUT_EN
//   defined   -> a watchdog bounds WAIT_DONE and raises the sticky Err flag
//   undefined -> WAIT_DONE waits for Done indefinitely, Err is tied low
//
// Handshake: Start is high for exactly one cycle, the cycle the FSM is in
// START. The sensor answers with a one-cycle Done pulse, and DataIn is only
// meaningful in that cycle. Done is honoured only in WAIT_DONE. Valid is a
// one-cycle pulse in the cycle after an honoured Done, the first cycle Temp
// shows the new reading. Neither side can stall the other.
module temp_sample_sequencer #(
  parameter int unsigned PERIOD  = 12500000,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              CLK,
  input  logic              Rst,
  input  logic              En,
  input  logic              Force,
  output logic              Start,
  input  logic              Done,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] Temp,
  output logic              Valid,
  output logic              Err,
  output logic [1:0]        State
);

  typedef enum logic [1:0] {
    S_WAIT      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  count;
  logic              tick;
  logic              done_ok;
  logic              timeout;

  // A period tick is only meaningful while idling with sampling enabled
  assign tick    = (state == S_WAIT) && En && (count == CNT_W'(PERIOD - 1));
  // Done only counts while a transaction is outstanding
  assign done_ok = (state == S_WAIT_DONE) && Done;

`ifdef TEMP_TIMEOUT_EN
  logic [15:0] wdog;

  // Watchdog counts from the START cycle so Err lands TIMEOUT cycles after Start; Done wins a tie
  assign timeout = (state == S_WAIT_DONE) && !Done && (wdog >= 16'(TIMEOUT - 1));

  // Watchdog runs through START and WAIT_DONE and is cleared whenever idle
  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      wdog <= '0;
    end else if (state == S_WAIT) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + 16'd1;
    end
  end

  // Err is sticky across timeouts and cleared only by a later good reading
  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      Err <= 1'b0;
    end else if (done_ok) begin
      Err <= 1'b0;
    end else if (timeout) begin
      Err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign Err     = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      state <= S_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: tick and Force merge into a single sample; Force is ignored outside WAIT
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:      if (Force || tick) state_nxt = S_START;
      S_START:     state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (done_ok || timeout) state_nxt = S_WAIT;
      default:     state_nxt = S_WAIT;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    Start = (state == S_START);
    State = state;
  end

  // Period counter advances only while idling with En; every other path restarts it from 0
  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      count <= '0;
    end else if ((state == S_WAIT) && En && !tick && !Force) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= '0;
    end
  end

  // Latch the reading and pulse Valid one cycle after an honoured Done
  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      Temp  <= '0;
      Valid <= 1'b0;
    end else begin
      Valid <= done_ok;
      if (done_ok) begin
        Temp <= DataIn;
      end
    end
  end

endmodule

// File: tb/tb_temp_sample_sequencer.sv
// tb_temp_sample_sequencer
// Drives temp_sample_sequencer with directed and randomized traffic. A
// behavioural predictor queues the cycles at which Start and Valid must appear,
// along with the Temp/Err levels. A separate monitor compares these against the
// DUT on the falling clock edge.
module tb_temp_sample_sequencer;

  localparam int PERIOD  = 10;
  localparam int TIMEOUT = 8;
  localparam int DATA_W  = 8;
`ifdef TEMP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- DUT
  logic              en      = 1'b0;
  logic              frc     = 1'b0;
  logic              done    = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              start;
  logic              valid;
  logic              err;
  logic [DATA_W-1:0] temp;
  logic [1:0]        state;

  temp_sample_sequencer #(
    .PERIOD (PERIOD),
    .CNT_W  (24),
    .TIMEOUT(TIMEOUT),
    .DATA_W (DATA_W)
  ) dut (
    .CLK   (clk),
    .Rst   (rst),
    .En    (en),
    .Force (frc),
    .Start (start),
    .Done  (done),
    .DataIn(data_in),
    .Temp  (temp),
    .Valid (valid),
    .Err   (err),
    .State (state)
  );

  // ---------------------------------------------------------------- stimulus controls
  logic              en_v        = 1'b0;
  logic              rst_v       = 1'b0;
  int                resp_delay  = 3;
  logic [DATA_W-1:0] resp_data   = '0;
  logic [DATA_W-1:0] stray_data  = '0;
  int                sched       = -1;
  int                bound_expired = 0;
  logic              sim_done    = 1'b0;

  // One clock of stimulus; the sensor model answers each Start after resp_delay cycles (0 = never)
  task automatic drive_cycle(input logic f, input logic stray);
    @(posedge clk);
    #1;
    if (!rst_v) sched = -1;
    else if (start && resp_delay > 0) sched = cyc + resp_delay;
    done = stray || (sched == cyc);
    if (sched == cyc) begin
      data_in = resp_data;
      sched   = -1;
    end else if (stray) begin
      data_in = stray_data;
    end else begin
      data_in = DATA_W'($urandom);
    end
    en  = en_v;
    frc = f;
    rst = rst_v;
  endtask

  task automatic run(input int n);
    repeat (n) drive_cycle(1'b0, 1'b0);
  endtask

  // Step until the DUT issues Start, bounded
  task automatic wait_start(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      drive_cycle(1'b0, 1'b0);
      if (start) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) bound_expired++;
  endtask

  // ---------------------------------------------------------------- reference model
  int                start_q[$];
  int                vcyc_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic              busy       = 1'b0;
  int                start_cyc  = 0;
  int                run_len    = 0;
  int                next_start = -1;
  logic              err_now    = 1'b0;
  logic              err_next   = 1'b0;
  logic [DATA_W-1:0] temp_now   = '0;
  logic [DATA_W-1:0] temp_next  = '0;

  // Sample rules: a sample begins after PERIOD consecutive enabled idle cycles or
  // one cycle after Force while idle; it ends on Done or, with the watchdog,
  // TIMEOUT-1 cycles after its Start cycle.
  initial forever begin
    @(posedge clk);
    #2;
    if (!rst) begin
      busy = 1'b0; run_len = 0; next_start = -1;
      err_now = 1'b0; err_next = 1'b0; temp_now = '0; temp_next = '0;
      start_q.delete(); vcyc_q.delete(); exp_q.delete();
    end else begin
      err_now  = err_next;
      temp_now = temp_next;
      if (next_start == cyc) begin
        start_q.push_back(cyc);
        busy = 1'b1; start_cyc = cyc; next_start = -1; run_len = 0;
      end else if (busy) begin
        if (done) begin
          vcyc_q.push_back(cyc + 1);
          exp_q.push_back(data_in);
          temp_next = data_in; err_next = 1'b0; busy = 1'b0; run_len = 0;
        end else if (TO_EN && (cyc - start_cyc >= TIMEOUT - 1)) begin
          err_next = 1'b1; busy = 1'b0; run_len = 0;
        end
      end else if (frc) begin
        next_start = cyc + 1;
      end else if (en) begin
        run_len++;
        if (run_len == PERIOD) next_start = cyc + 1;
      end else begin
        run_len = 0;
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard / monitor
  int checks     = 0;
  int errors     = 0;
  int bound_seen = 0;

  initial forever begin
    @(negedge clk);
    while (bound_seen < bound_expired) begin
      bound_seen++; checks++; errors++;
      $display("FAIL wait_bound: no Start within budget near cycle %0d, state=%0d", cyc, state);
    end
    if (!rst) begin
      checks++;
      if (start !== 1'b0 || valid !== 1'b0 || temp !== '0 || err !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: cycle %0d got start=%b valid=%b temp=%h err=%b, want all 0",
                 cyc, start, valid, temp, err);
      end
    end else begin
      checks++;
      if (start && valid) begin
        errors++;
        $display("FAIL start_valid_overlap: cycle %0d got both high, want at most one", cyc);
      end
      while (start_q.size() > 0 && start_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL start_missing: no Start at cycle %0d, want Start=1", start_q[0]);
        void'(start_q.pop_front());
      end
      if (start) begin
        checks++;
        if (start_q.size() > 0 && start_q[0] == cyc) begin
          void'(start_q.pop_front());
        end else begin
          errors++;
          $display("FAIL start_unexpected: Start=1 at cycle %0d, next expected %0d",
                   cyc, (start_q.size() > 0) ? start_q[0] : -1);
        end
      end
      while (vcyc_q.size() > 0 && vcyc_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL valid_missing: no Valid at cycle %0d, want Valid=1 with temp=%h",
                 vcyc_q[0], exp_q[0]);
        void'(vcyc_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (valid) begin
        checks++;
        if (vcyc_q.size() > 0 && vcyc_q[0] == cyc) begin
          if (temp !== exp_q[0]) begin
            errors++;
            $display("FAIL valid_temp: cycle %0d got temp=%h, want %h", cyc, temp, exp_q[0]);
          end
          void'(vcyc_q.pop_front());
          void'(exp_q.pop_front());
        end else begin
          errors++;
          $display("FAIL valid_unexpected: Valid=1 at cycle %0d, none expected", cyc);
        end
      end
      checks++;
      if (err !== err_now) begin
        errors++;
        $display("FAIL err_level: cycle %0d got err=%b, want %b", cyc, err, err_now);
      end
      checks++;
      if (temp !== temp_now) begin
        errors++;
        $display("FAIL temp_level: cycle %0d got temp=%h, want %h", cyc, temp, temp_now);
      end
    end
    if (sim_done) begin
      checks++;
      if (start_q.size() != 0 || vcyc_q.size() != 0) begin
        errors++;
        $display("FAIL leftover: %0d Start and %0d Valid still expected, want 0 and 0",
                 start_q.size(), vcyc_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  // ---------------------------------------------------------------- scenarios
  initial begin
    int c;
    // Reset held, then periodic sampling with a 3-cycle sensor and reading 0x19
    resp_delay = 3;
    resp_data  = 8'h19;
    run(4);
    en_v  = 1'b1;
    rst_v = 1'b1;
    repeat (3) wait_start(c);
    run(2);

    // Force while count==4: Start follows next cycle, then the normal period resumes
    wait_start(c);
    run(7);
    resp_data = DATA_W'($urandom_range(1, 255));
    drive_cycle(1'b1, 1'b0);
    repeat (2) wait_start(c);
    run(4);

    // Sensor silent: watchdog fires (when built), then a reading of 0x1A recovers
    resp_delay = 0;
    wait_start(c);
    run(TIMEOUT + 2);
    resp_data = 8'h1A;
`ifdef TEMP_TIMEOUT_EN
    resp_delay = TIMEOUT - 1;
    wait_start(c);
    run(TIMEOUT + 2);
`else
    stray_data = 8'h1A;
    drive_cycle(1'b0, 1'b1);
    run(3);
`endif

    // Done on the last watchdog cycle with Err already clear
    resp_delay = TIMEOUT - 1;
    resp_data  = DATA_W'($urandom_range(1, 255));
    wait_start(c);
    run(TIMEOUT + 2);

    // En dropped during WAIT_DONE: the reading still lands, then no further Start
    resp_delay = 4;
    resp_data  = DATA_W'($urandom_range(1, 255));
    wait_start(c);
    en_v = 1'b0;
    run(40);

    // Done while idle and while in START is ignored
    stray_data = ~resp_data;
    drive_cycle(1'b0, 1'b1);
    run(2);
    resp_delay = 2;
    resp_data  = DATA_W'($urandom_range(1, 255));
    stray_data = ~resp_data;
    drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1);
    run(6);

    // Reset during WAIT_DONE, then a fresh period after release
    en_v       = 1'b1;
    resp_delay = 0;
    wait_start(c);
    run(3);
    @(posedge clk);
    #3;
    rst   = 1'b0;
    rst_v = 1'b0;
    sched = -1;
    run(3);
    rst_v      = 1'b1;
    resp_delay = 3;
    resp_data  = DATA_W'($urandom_range(1, 255));
    run(30);

    // Randomized traffic: En toggling, occasional Force and stray Done, varied sensor latency
    for (int i = 0; i < 400; i++) begin
      if ((i % 25) == 0) en_v = ($urandom_range(0, 3) != 0);
      resp_delay = $urandom_range(1, 10);
      resp_data  = DATA_W'($urandom);
      stray_data = DATA_W'($urandom);
      drive_cycle($urandom_range(0, 15) == 0, $urandom_range(0, 29) == 0);
    end

    // Drain outstanding work, then let the monitor report
    en_v       = 1'b0;
    resp_delay = 2;
    run(30);
    sim_done = 1'b1;
  end

endmodule
